// File: rtl/vmx_execute_sequencer.sv
// -----------------------------------------------------------------------------
// vmx_execute_sequencer
//
// Sequences weight-load (SETW) and vector (RUN) commands onto a systolic PE
// array. Input vectors are skewed one cycle per lane toward the array and the
// returned products are deskewed back into whole vectors. The whole vectors
// are then buffered in an output FIFO. A credit rule keeps the number of
// vectors in flight plus buffered within the FIFO depth, so the FIFO never
// overflows.
//
// Ports
//   clk, rst (async, active-high), sw_rst (sync clear), halt (freeze)
//   cmd_data/cmd_valid/cmd_ready  : command word, opcode [3:0], count N [15:8]
//   in_data/in_valid/in_ready     : PE_SIZE lanes of PORT_WIDTH bits
//   out_data/out_valid/out_ready  : PE_SIZE lanes of ACC_WIDTH bits
//   pe_load_ctrl                  : per-column {load, row[6:0]} to the array
//   pe_vector                     : skewed input lanes to the array
//   pe_product                    : product lanes returned by the array
//   busy                          : state is not IDLE
//   cmd_err                       : one-cycle pulse on an illegal command
//
// Optional feature macro: VMX_EXEC_PERF_EN
//   Adds perf_busy_cycles and perf_vectors, which are saturating 32-bit counts
//   of busy cycles and of accepted RUN vectors.
// -----------------------------------------------------------------------------
module vmx_execute_sequencer #(
    parameter int PE_SIZE    = 4,
    parameter int PORT_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int PE_LAT     = 4,
    parameter int OUT_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sw_rst,
    input  logic                            halt,
    input  logic [31:0]                     cmd_data,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [PE_SIZE*PORT_WIDTH-1:0]   in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [PE_SIZE*ACC_WIDTH-1:0]    out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [8*PE_SIZE-1:0]            pe_load_ctrl,
    output logic [PE_SIZE*PORT_WIDTH-1:0]   pe_vector,
    input  logic [PE_SIZE*ACC_WIDTH-1:0]    pe_product,
    output logic                            busy,
    output logic                            cmd_err
`ifdef VMX_EXEC_PERF_EN
    ,
    output logic [31:0]                     perf_busy_cycles,
    output logic [31:0]                     perf_vectors
`endif
);

    localparam int RES_W   = PE_SIZE * ACC_WIDTH;
    localparam int TRK_LEN = PE_LAT + PE_SIZE;
    localparam int AW      = $clog2(OUT_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [1:0] {IDLE, SETW, RUN, DRAIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic [7:0]         r_n, w_n_nxt;
    logic               r_cmd_err, w_cmd_err_nxt;

    logic [TRK_LEN-1:0] r_vld_sr;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [RES_W-1:0]   r_mem [OUT_DEPTH];

    logic               w_cmd_fire, w_in_fire, w_run_fire, w_setw_fire;
    logic               w_push, w_pop;
    logic [CW:0]        w_credit;
    logic [7:0]         w_load_word;
    logic [RES_W-1:0]   w_aligned;
    logic               w_unused_cmd_bits;

    assign w_unused_cmd_bits = ^{cmd_data[31:16], cmd_data[7:4]};

    // Handshakes
    assign w_credit    = {1'b0, r_inflight} + {1'b0, r_count};
    assign cmd_ready   = (r_state == IDLE) && !halt;
    assign in_ready    = !halt && ((r_state == SETW) ||
                         ((r_state == RUN) && (w_credit < (CW+1)'(OUT_DEPTH))));
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_in_fire   = in_valid && in_ready;
    assign w_run_fire  = w_in_fire && (r_state == RUN);
    assign w_setw_fire = w_in_fire && (r_state == SETW);
    assign w_load_word = {1'b1, r_cnt[6:0]};

    assign busy    = (r_state != IDLE);
    assign cmd_err = r_cmd_err;

    // FSM next state
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_n_nxt       = r_n;
        w_cmd_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_cnt_nxt = 8'd0;
                    if (cmd_data[3:0] == 4'd0) begin
                        w_state_nxt = SETW;
                    end else if ((cmd_data[3:0] == 4'd1) && (cmd_data[15:8] != 8'd0)) begin
                        w_state_nxt = RUN;
                        w_n_nxt     = cmd_data[15:8];
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end
            SETW: begin
                if (w_in_fire) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == 8'(PE_SIZE - 1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            RUN: begin
                if (w_in_fire) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == (r_n - 8'd1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((r_inflight == '0) && (r_count == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_n       <= 8'd0;
            r_cmd_err <= 1'b0;
        end else if (sw_rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_n       <= 8'd0;
            r_cmd_err <= 1'b0;
        end else if (!halt) begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_n       <= w_n_nxt;
            r_cmd_err <= w_cmd_err_nxt;
        end
    end

    // In-flight tracking. An accepted RUN vector emerges from this shift
    // register in the same cycle as its deskewed products become aligned.
    assign w_push = r_vld_sr[TRK_LEN-1] && !halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_sr   <= '0;
            r_inflight <= '0;
        end else if (sw_rst) begin
            r_vld_sr   <= '0;
            r_inflight <= '0;
        end else if (!halt) begin
            r_vld_sr <= {r_vld_sr[TRK_LEN-2:0], w_run_fire};
            case ({w_run_fire, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Per-lane skew toward the array and deskew of the returned products
    genvar k;
    generate
        for (k = 0; k < PE_SIZE; k++) begin : g_lane
            logic [PORT_WIDTH-1:0] r_vsk [k+1];
            logic [7:0]            r_lsk [k+1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j <= k; j++) begin
                        r_vsk[j] <= '0;
                        r_lsk[j] <= 8'h00;
                    end
                end else if (sw_rst) begin
                    for (int j = 0; j <= k; j++) begin
                        r_vsk[j] <= '0;
                        r_lsk[j] <= 8'h00;
                    end
                end else if (!halt) begin
                    r_vsk[0] <= w_run_fire ? in_data[k*PORT_WIDTH +: PORT_WIDTH] : '0;
                    r_lsk[0] <= w_setw_fire ? w_load_word : 8'h00;
                    for (int j = 1; j <= k; j++) begin
                        r_vsk[j] <= r_vsk[j-1];
                        r_lsk[j] <= r_lsk[j-1];
                    end
                end
            end

            assign pe_vector[k*PORT_WIDTH +: PORT_WIDTH] = r_vsk[k];
            assign pe_load_ctrl[k*8 +: 8]                = r_lsk[k];

            // The last lane arrives latest, so it needs no deskew.
            if (k == PE_SIZE - 1) begin : g_direct
                assign w_aligned[k*ACC_WIDTH +: ACC_WIDTH] = pe_product[k*ACC_WIDTH +: ACC_WIDTH];
            end else begin : g_deskew
                localparam int D = PE_SIZE - 1 - k;
                logic [ACC_WIDTH-1:0] r_dsk [D];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int j = 0; j < D; j++) r_dsk[j] <= '0;
                    end else if (sw_rst) begin
                        for (int j = 0; j < D; j++) r_dsk[j] <= '0;
                    end else if (!halt) begin
                        r_dsk[0] <= pe_product[k*ACC_WIDTH +: ACC_WIDTH];
                        for (int j = 1; j < D; j++) r_dsk[j] <= r_dsk[j-1];
                    end
                end

                assign w_aligned[k*ACC_WIDTH +: ACC_WIDTH] = r_dsk[D-1];
            end
        end
    endgenerate

    // Output FIFO
    assign out_valid = (r_count != '0) && !halt;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (sw_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (!halt) begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_aligned;
        end
    end

`ifdef VMX_EXEC_PERF_EN
    logic [31:0] r_perf_busy, r_perf_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_busy <= 32'd0;
            r_perf_vec  <= 32'd0;
        end else if (sw_rst) begin
            r_perf_busy <= 32'd0;
            r_perf_vec  <= 32'd0;
        end else if (!halt) begin
            if (busy && (r_perf_busy != 32'hFFFF_FFFF)) r_perf_busy <= r_perf_busy + 32'd1;
            if (w_run_fire && (r_perf_vec != 32'hFFFF_FFFF)) r_perf_vec <= r_perf_vec + 32'd1;
        end
    end

    assign perf_busy_cycles = r_perf_busy;
    assign perf_vectors     = r_perf_vec;
`endif

endmodule

// File: doc/vmx_execute_sequencer.md
VMX_EXECUTE_SEQUENCER -- requirements
Module: vmx_execute_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PE_SIZE, 4, PE array rows, columns and lanes (2..16).
- PORT_WIDTH, 16, input lane width in bits.
- ACC_WIDTH, 32, product lane width in bits.
- PE_LAT, 4, cycles from skewed lane-k input to lane-k pe_product.
- OUT_DEPTH, 8, output FIFO entries (power of 2, at least 2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- sw_rst, in, 1, synchronous clear.
- halt, in, 1, freezes all state.
- cmd_data, in, 32, command word.
- cmd_valid, in, 1, command handshake.
- cmd_ready, out, 1, command handshake.
- in_data, in, PE_SIZE*PORT_WIDTH, vector beat.
- in_valid, in, 1, vector handshake.
- in_ready, out, 1, vector handshake.
- out_data, out, PE_SIZE*ACC_WIDTH, result vector.
- out_valid, out, 1, result handshake.
- out_ready, in, 1, result handshake.
- pe_load_ctrl, out, 8*PE_SIZE, per-column weight-load control to PE array.
- pe_vector, out, PE_SIZE*PORT_WIDTH, skewed input vector to PE array.
- pe_product, in, PE_SIZE*ACC_WIDTH, PE array products.
- busy, out, 1, high whenever state is not IDLE.
- cmd_err, out, 1, one-cycle pulse on an illegal command.

Function
REQ-003 The state machine SHALL have states IDLE, SETW, RUN and DRAIN.
REQ-004 A transfer SHALL occur only when valid and ready are both high and halt is low.
REQ-005 cmd_ready SHALL be high only in IDLE with halt low.
REQ-006 The command fields SHALL be: cmd_data[3:0] opcode (0 SETW, 1 RUN) and cmd_data[15:8] vector count N.
REQ-007 Any other opcode, or RUN with N=0, SHALL be consumed, pulse cmd_err for one cycle, and leave the state IDLE.
REQ-008 In SETW, in_ready SHALL be high and the block SHALL accept exactly PE_SIZE beats, then return to IDLE.
REQ-009 SETW beat r SHALL drive pe_load_ctrl column k with {1'b1, r[6:0]} delayed k cycles; all other cycles SHALL drive 8'h00.
REQ-010 In RUN, the block SHALL accept N beats; in_ready SHALL be high only when (in-flight + FIFO occupancy) < OUT_DEPTH.
REQ-011 After the Nth RUN beat the state SHALL become DRAIN, and SHALL return to IDLE when in-flight and FIFO occupancy are both zero.
REQ-012 Input lane k SHALL be delayed k cycles onto pe_vector lane k; lanes with no accepted beat SHALL drive zero.
REQ-013 Product lane k SHALL be deskewed by (PE_SIZE-1-k) cycles, so that a vector accepted at cycle t is pushed into the FIFO at t+PE_LAT+PE_SIZE.
REQ-014 Result data SHALL pass through unmodified; lane k SHALL occupy out_data[k*ACC_WIDTH +: ACC_WIDTH].
REQ-015 out_valid SHALL equal FIFO non-empty and halt low; simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-016 The FIFO SHALL never overflow, by virtue of the credit rule in REQ-010.
REQ-017 While halt is high, all registers SHALL hold their values, and cmd_ready, in_ready and out_valid SHALL be low.
REQ-018 Vector results SHALL leave the block in input order.

Reset
REQ-019 rst SHALL asynchronously set: state IDLE, counters 0, FIFO empty, in-flight tracking 0, skew pipelines 0, pe_load_ctrl 0, cmd_err 0.
REQ-020 sw_rst SHALL have the same effect as rst on the next clock edge, and SHALL take priority over halt.
REQ-021 A reset asserted mid-operation SHALL abort the command; the next command SHALL behave as if issued from power-up.

Configuration
REQ-022 With VMX_EXEC_PERF_EN defined, the block SHALL add two 32-bit outputs, perf_busy_cycles and perf_vectors, which are saturating, cleared by rst and sw_rst, and frozen by halt.
REQ-023 Without VMX_EXEC_PERF_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 The bench SHALL cover these scenarios:
- SETW (PE_SIZE=4) -> column 0 sees 8'h80..8'h83 on consecutive cycles; column 3 sees the same sequence 3 cycles later; busy falls after 4 beats.
- RUN N=3 with out_ready=1 and a PE model of product = input → 3 results in order; the first appears at acceptance+PE_LAT+PE_SIZE+1.
- RUN N=20 with out_ready=0 → in_ready drops after 8 accepts; no FIFO overflow; all 20 results in order after out_ready=1.
- opcode 7, then RUN N=0 → each pulses cmd_err once; busy stays 0.
- halt for 5 cycles mid-RUN → the result sequence matches the run without halt.
- rst mid-DRAIN → out_valid=0 and busy=0 immediately; a subsequent RUN N=1 returns one correct result.
